// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-ST message path
// (packetizer, enforcer and future depacketizers).
package avalon_pkg;

  // Widest data bus, in bytes, that byte_mask_func can describe.
  localparam int MAX_BYTES = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } msg_sm_t;

  function automatic int log2up_func(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Bit i is set when byte lane i (lane 0 = least significant) survives `empty` trailing bytes.
  function automatic logic [MAX_BYTES-1:0] byte_mask_func(input int unsigned empty);
    logic [MAX_BYTES-1:0] mask;
    for (int i = 0; i < MAX_BYTES; i++) begin
      mask[i] = (unsigned'(i) >= empty);
    end
    return mask;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST link: big-endian byte order inside data, empty counts unused low bytes on eop.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
);
  import avalon_pkg::*;

  localparam int EMPTY_WIDTH = log2up_func(DATA_WIDTH_IN_BYTES);

  logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
  logic                             valid;
  logic                             ready;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_WIDTH-1:0]           empty;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);

endinterface

// File: rtl/avalon_len_calc.sv
// Maps a message byte length to its word count and the empty byte count of its last word.
module avalon_len_calc
  import avalon_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 4,
  parameter int LEN_WIDTH           = 16
) (
  input  logic [LEN_WIDTH-1:0]                         cmd_len_i,
  output logic [LEN_WIDTH-1:0]                         words_total_o,
  output logic [log2up_func(DATA_WIDTH_IN_BYTES)-1:0]  last_empty_o
);

  localparam int SHIFT = log2up_func(DATA_WIDTH_IN_BYTES);

  logic [SHIFT-1:0] tail_bytes;

  assign tail_bytes    = cmd_len_i[SHIFT-1:0];
  // Ceiling divide by a power of two: whole words plus one for any partial tail.
  assign words_total_o = (cmd_len_i >> SHIFT) + LEN_WIDTH'(|tail_bytes);
  // (W - tail) mod W is just the negated tail truncated to SHIFT bits.
  assign last_empty_o  = SHIFT'(0) - tail_bytes;

endmodule

// File: rtl/avalon_packetizer.sv
// Transmit-side framer: turns a length command plus a raw word stream into
// sop/eop/empty-framed Avalon-ST messages with zeroed trailing bytes.
module avalon_packetizer
  import avalon_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 4,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  avalon_st_if.slave           raw_data,
  avalon_st_if.master          framed_msg,
  output logic                 zero_len_indi,
  output logic                 msg_done_indi,
  output logic [15:0]          msg_count
);

  localparam int EMPTY_WIDTH = log2up_func(DATA_WIDTH_IN_BYTES);
  localparam int DATA_WIDTH  = DATA_WIDTH_IN_BYTES * 8;

  msg_sm_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]   words_total_q, words_total_d;
  logic [LEN_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic [EMPTY_WIDTH-1:0] last_empty_q, last_empty_d;
  logic                   first_q, first_d;
  logic [15:0]            msg_count_q, msg_count_d;
  logic                   msg_done_q, msg_done_d;
  logic                   zero_len_q, zero_len_d;

  logic [LEN_WIDTH-1:0]   calc_words_total;
  logic [EMPTY_WIDTH-1:0] calc_last_empty;
  logic                   cmd_accept;
  logic                   beat;
  logic                   is_last;
  logic [MAX_BYTES-1:0]   lane_keep_all;
  logic [DATA_WIDTH-1:0]  keep_bits;
  logic                   unused_sig;

  avalon_len_calc #(
    .DATA_WIDTH_IN_BYTES (DATA_WIDTH_IN_BYTES),
    .LEN_WIDTH           (LEN_WIDTH)
  ) u_len_calc (
    .cmd_len_i     (cmd_len),
    .words_total_o (calc_words_total),
    .last_empty_o  (calc_last_empty)
  );

  assign cmd_accept = cmd_valid & cmd_ready;
  assign beat       = (state_q == SEND) & raw_data.valid & framed_msg.ready;
  assign is_last    = (word_cnt_q == words_total_q - LEN_WIDTH'(1));

  assign lane_keep_all = byte_mask_func({{(32-EMPTY_WIDTH){1'b0}}, last_empty_q});

  for (genvar gi = 0; gi < DATA_WIDTH_IN_BYTES; gi++) begin : g_lane_keep
    assign keep_bits[gi*8 +: 8] = {8{lane_keep_all[gi]}};
  end

  // Raw-side framing fields are meaningless here and the wide mask only needs W lanes.
  assign unused_sig = ^{lane_keep_all[MAX_BYTES-1:DATA_WIDTH_IN_BYTES],
                        raw_data.sop, raw_data.eop, raw_data.empty};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_accept && (cmd_len != '0)) state_d = SEND;
      SEND:    if (beat && is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready        = 1'b0;
    raw_data.ready   = 1'b0;
    framed_msg.valid = 1'b0;
    framed_msg.sop   = 1'b0;
    framed_msg.eop   = 1'b0;
    framed_msg.empty = '0;
    framed_msg.data  = '0;
    case (state_q)
      IDLE: cmd_ready = 1'b1;
      SEND: begin
        framed_msg.valid = raw_data.valid;
        raw_data.ready   = framed_msg.ready;
        if (raw_data.valid) begin
          framed_msg.sop   = first_q;
          framed_msg.eop   = is_last;
          framed_msg.empty = is_last ? last_empty_q : '0;
          framed_msg.data  = is_last ? (raw_data.data & keep_bits) : raw_data.data;
        end
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  always_comb begin
    words_total_d = words_total_q;
    last_empty_d  = last_empty_q;
    word_cnt_d    = word_cnt_q;
    first_d       = first_q;
    msg_count_d   = msg_count_q;
    msg_done_d    = 1'b0;
    zero_len_d    = 1'b0;
    if (cmd_accept) begin
      if (cmd_len == '0) begin
        zero_len_d = 1'b1;
      end else begin
        words_total_d = calc_words_total;
        last_empty_d  = calc_last_empty;
        word_cnt_d    = '0;
        first_d       = 1'b1;
      end
    end
    if (beat) begin
      word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
      first_d    = 1'b0;
      if (is_last) begin
        msg_count_d = msg_count_q + 16'd1;
        msg_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_total_q <= '0;
      last_empty_q  <= '0;
      word_cnt_q    <= '0;
      first_q       <= 1'b0;
      msg_count_q   <= '0;
      msg_done_q    <= 1'b0;
      zero_len_q    <= 1'b0;
    end else begin
      words_total_q <= words_total_d;
      last_empty_q  <= last_empty_d;
      word_cnt_q    <= word_cnt_d;
      first_q       <= first_d;
      msg_count_q   <= msg_count_d;
      msg_done_q    <= msg_done_d;
      zero_len_q    <= zero_len_d;
    end
  end

  assign msg_count     = msg_count_q;
  assign msg_done_indi = msg_done_q;
  assign zero_len_indi = zero_len_q;

endmodule

// File: tb/tb_avalon_packetizer.sv
// Self-checking bench for avalon_packetizer with W = 4: randomized payloads and
// stalls checked against a byte-level model of how a message is framed.
module tb_avalon_packetizer;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        zero_len_indi;
  logic        msg_done_indi;
  logic [15:0] msg_count;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) raw_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) out_if ();

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count;
  logic [31:0] pay_mem [0:15];

  avalon_packetizer #(
    .DATA_WIDTH_IN_BYTES (W),
    .LEN_WIDTH           (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .raw_data      (raw_if),
    .framed_msg    (out_if),
    .zero_len_indi (zero_len_indi),
    .msg_done_indi (msg_done_indi),
    .msg_count     (msg_count)
  );

  always #5 clk = ~clk;

  // Word k of a len-byte message: stream byte 4k+b sits in lane b counted from the MSB;
  // bytes past the end of the message must read as zero.
  function automatic logic [31:0] exp_word(input logic [31:0] w, input int k, input int len);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      if (k * W + b < len) r[31-8*b -: 8] = w[31-8*b -: 8];
    end
    return r;
  endfunction

  // Issues one command, streams its payload under random stalls and checks every cycle.
  task automatic run_msg(input int len, input int rdy_pct, input int vld_pct);
    int   nwords;
    int   k;
    int   cyc;
    int   exp_empty;
    bit   fired;
    bit   got;
    nwords = (len + W - 1) / W;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 16'(len);
    got = 1'b0;
    for (cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (cmd_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL cmd_accept len=%0d: cmd_ready stayed %b, required 1", len, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = 16'($urandom);
    k     = 0;
    fired = 1'b0;
    for (cyc = 0; cyc < 500 && k < nwords; cyc++) begin
      if (fired) raw_if.valid = 1'b0;
      if (!raw_if.valid) begin
        raw_if.data = $urandom;
        if ($urandom_range(99) < vld_pct) begin
          raw_if.valid = 1'b1;
          raw_if.data  = pay_mem[k];
        end
      end
      out_if.ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (raw_if.valid) begin
        exp_empty = (k == nwords - 1) ? nwords * W - len : 0;
        checks++;
        if (out_if.valid !== 1'b1) begin
          errors++;
          $display("FAIL valid len=%0d word=%0d: got %b, required 1", len, k, out_if.valid);
        end
        checks++;
        if (out_if.sop !== (k == 0)) begin
          errors++;
          $display("FAIL sop len=%0d word=%0d: got %b, required %b", len, k, out_if.sop, (k == 0));
        end
        checks++;
        if (out_if.eop !== (k == nwords - 1)) begin
          errors++;
          $display("FAIL eop len=%0d word=%0d: got %b, required %b", len, k, out_if.eop, (k == nwords - 1));
        end
        checks++;
        if (out_if.empty !== 2'(exp_empty)) begin
          errors++;
          $display("FAIL empty len=%0d word=%0d: got %0d, required %0d", len, k, out_if.empty, exp_empty);
        end
        checks++;
        if (out_if.data !== exp_word(pay_mem[k], k, len)) begin
          errors++;
          $display("FAIL data len=%0d word=%0d: got %h, required %h", len, k, out_if.data,
                   exp_word(pay_mem[k], k, len));
        end
      end else begin
        checks++;
        if ({out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data} !== '0) begin
          errors++;
          $display("FAIL idle_drive len=%0d word=%0d: got v=%b s=%b e=%b emp=%0d d=%h, required all 0",
                   len, k, out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data);
        end
      end
      checks++;
      if (raw_if.ready !== out_if.ready) begin
        errors++;
        $display("FAIL ready_pass len=%0d word=%0d: got %b, required %b", len, k, raw_if.ready, out_if.ready);
      end
      fired = raw_if.valid && out_if.ready;
      @(posedge clk);
      if (fired) k++;
      @(negedge clk);
    end
    checks++;
    if (k < nwords) begin
      errors++;
      $display("FAIL msg_timeout len=%0d: got %0d words, required %0d", len, k, nwords);
    end
    raw_if.valid = 1'b0;
    out_if.ready = 1'b1;
    exp_count    = exp_count + 16'd1;
    #1;
    checks++;
    if (msg_done_indi !== 1'b1) begin
      errors++;
      $display("FAIL msg_done_pulse len=%0d: got %b, required 1", len, msg_done_indi);
    end
    checks++;
    if (msg_count !== exp_count) begin
      errors++;
      $display("FAIL msg_count len=%0d: got %h, required %h", len, msg_count, exp_count);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL back_to_idle len=%0d: cmd_ready got %b, required 1", len, cmd_ready);
    end
    // A word offered after the eop must not leak out as an extra beat.
    raw_if.valid = 1'b1;
    raw_if.data  = $urandom;
    #1;
    checks++;
    if (out_if.valid !== 1'b0 || raw_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL extra_beat len=%0d: valid=%b ready=%b, required 0 and 0", len, out_if.valid, raw_if.ready);
    end
    @(negedge clk);
    raw_if.valid = 1'b0;
    #1;
    checks++;
    if (msg_done_indi !== 1'b0) begin
      errors++;
      $display("FAIL msg_done_width len=%0d: got %b, required 0", len, msg_done_indi);
    end
    $display("msg len=%0d words=%0d rdy=%0d%% vld=%0d%% count=%h", len, nwords, rdy_pct, vld_pct, msg_count);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data, raw_if.ready} !== '0) begin
      errors++;
      $display("FAIL reset_stream: got v=%b s=%b e=%b d=%h rdy=%b, required all 0",
               out_if.valid, out_if.sop, out_if.eop, out_if.data, raw_if.ready);
    end
    checks++;
    if ({msg_count, msg_done_indi, zero_len_indi} !== '0) begin
      errors++;
      $display("FAIL reset_status: got count=%h done=%b zero=%b, required 0", msg_count, msg_done_indi, zero_len_indi);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
    $display("reset released");
  endtask

  task automatic test_basic();
    pay_mem[0] = 32'h01020304;
    pay_mem[1] = 32'h05060708;
    pay_mem[2] = 32'h090A0B0C;
    run_msg(10, 100, 100);
  endtask

  task automatic test_single_word();
    pay_mem[0] = $urandom;
    run_msg(4, 100, 100);
    pay_mem[0] = 32'hABCDEF12;
    run_msg(1, 100, 100);
  endtask

  task automatic test_zero_len();
    int pulses;
    bit bad_valid;
    bit bad_ready;
    pulses    = 0;
    bad_valid = 1'b0;
    bad_ready = 1'b0;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_len      = 16'd0;
    raw_if.valid = 1'b1;
    raw_if.data  = $urandom;
    out_if.ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (zero_len_indi === 1'b1) pulses++;
      if (out_if.valid !== 1'b0) bad_valid = 1'b1;
      if (cmd_ready !== 1'b1) bad_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    raw_if.valid = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL zero_len_pulse: got %0d cycles high, required 1", pulses);
    end
    checks++;
    if (bad_valid) begin
      errors++;
      $display("FAIL zero_len_beats: got output valid, required none");
    end
    checks++;
    if (bad_ready) begin
      errors++;
      $display("FAIL zero_len_cmd_ready: got 0 at some cycle, required 1 throughout");
    end
    checks++;
    if (msg_count !== exp_count) begin
      errors++;
      $display("FAIL zero_len_count: got %h, required %h", msg_count, exp_count);
    end
    $display("zero-length command pulses=%0d", pulses);
  endtask

  task automatic test_random_stalls();
    int len;
    for (int i = 0; i < 4; i++) pay_mem[i] = $urandom;
    run_msg(16, 50, 50);
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(64, 1);
      for (int i = 0; i < 16; i++) pay_mem[i] = $urandom;
      run_msg(len, $urandom_range(100, 30), $urandom_range(100, 30));
    end
  endtask

  task automatic test_back_to_back();
    int          bcyc [4];
    logic [1:0]  bemp [4];
    logic [31:0] bdat [4];
    logic [3:0]  sop_vec;
    logic [3:0]  eop_vec;
    int          acc_cyc [2];
    int          nb;
    int          na;
    int          idx;
    bit          fire;
    for (int i = 0; i < 4; i++) begin
      pay_mem[i] = $urandom;
      bcyc[i]    = -100;
      bemp[i]    = '0;
      bdat[i]    = '0;
    end
    acc_cyc[0] = -100;
    acc_cyc[1] = -100;
    sop_vec = '0;
    eop_vec = '0;
    nb  = 0;
    na  = 0;
    idx = 0;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_len      = 16'd8;
    out_if.ready = 1'b1;
    raw_if.valid = 1'b1;
    raw_if.data  = pay_mem[0];
    for (int c = 0; c < 16; c++) begin
      #1;
      if (cmd_valid && cmd_ready === 1'b1 && na < 2) begin
        acc_cyc[na] = c;
        na++;
      end
      fire = raw_if.valid && (raw_if.ready === 1'b1);
      if (out_if.valid === 1'b1) begin
        if (nb < 4) begin
          bcyc[nb]    = c;
          bemp[nb]    = out_if.empty;
          bdat[nb]    = out_if.data;
          sop_vec[nb] = out_if.sop;
          eop_vec[nb] = out_if.eop;
        end
        nb++;
      end
      @(posedge clk);
      if (fire) idx++;
      @(negedge clk);
      if (na == 1) cmd_len = 16'd5;
      if (na == 2) cmd_valid = 1'b0;
      raw_if.valid = (idx < 4);
      raw_if.data  = pay_mem[idx];
    end
    cmd_valid    = 1'b0;
    raw_if.valid = 1'b0;
    exp_count    = exp_count + 16'd2;
    #1;
    checks++;
    if (nb != 4 || na != 2) begin
      errors++;
      $display("FAIL b2b_counts: got %0d beats %0d accepts, required 4 and 2", nb, na);
    end
    checks++;
    if (bcyc[0] < acc_cyc[0] + 1) begin
      errors++;
      $display("FAIL b2b_cmd_latency: first beat cycle %0d, required >= %0d", bcyc[0], acc_cyc[0] + 1);
    end
    checks++;
    if (bcyc[2] - bcyc[1] != 2 || acc_cyc[1] != bcyc[1] + 1) begin
      errors++;
      $display("FAIL b2b_bubble: eop@%0d accept@%0d sop@%0d, required accept=eop+1 and sop=eop+2",
               bcyc[1], acc_cyc[1], bcyc[2]);
    end
    checks++;
    if (sop_vec !== 4'b0101 || eop_vec !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_framing: got sop=%b eop=%b, required sop=0101 eop=1010", sop_vec, eop_vec);
    end
    checks++;
    if (bemp[1] !== 2'd0 || bemp[3] !== 2'd3) begin
      errors++;
      $display("FAIL b2b_empty: got %0d and %0d, required 0 and 3", bemp[1], bemp[3]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bdat[k] !== exp_word(pay_mem[k], k % 2, (k < 2) ? 8 : 5)) begin
        errors++;
        $display("FAIL b2b_data beat=%0d: got %h, required %h", k, bdat[k],
                 exp_word(pay_mem[k], k % 2, (k < 2) ? 8 : 5));
      end
    end
    checks++;
    if (msg_count !== exp_count) begin
      errors++;
      $display("FAIL b2b_count: got %h, required %h", msg_count, exp_count);
    end
    $display("back-to-back beats=%0d accepts=%0d count=%h", nb, na, msg_count);
  endtask

  task automatic test_reset_mid_msg();
    for (int i = 0; i < 3; i++) pay_mem[i] = $urandom;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_len      = 16'd12;
    out_if.ready = 1'b1;
    raw_if.valid = 1'b0;
    @(negedge clk);
    cmd_valid    = 1'b0;
    raw_if.valid = 1'b1;
    raw_if.data  = pay_mem[0];
    #1;
    checks++;
    if (out_if.valid !== 1'b1 || out_if.sop !== 1'b1) begin
      errors++;
      $display("FAIL abort_first_word: got v=%b sop=%b, required 1 1", out_if.valid, out_if.sop);
    end
    @(negedge clk);
    raw_if.data = pay_mem[1];
    @(negedge clk);
    rst         = 1'b0;
    raw_if.data = pay_mem[2];
    #1;
    checks++;
    if ({out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data, raw_if.ready} !== '0) begin
      errors++;
      $display("FAIL abort_stream: got v=%b s=%b e=%b d=%h rdy=%b, required all 0",
               out_if.valid, out_if.sop, out_if.eop, out_if.data, raw_if.ready);
    end
    checks++;
    if ({msg_count, msg_done_indi, zero_len_indi} !== '0) begin
      errors++;
      $display("FAIL abort_status: got count=%h done=%b zero=%b, required 0", msg_count, msg_done_indi, zero_len_indi);
    end
    repeat (2) @(negedge clk);
    rst          = 1'b1;
    raw_if.valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_cmd_ready: got %b, required 1", cmd_ready);
    end
    exp_count = 16'd0;
    $display("reset mid-message, reframing");
    for (int i = 0; i < 3; i++) pay_mem[i] = $urandom;
    run_msg(12, 80, 80);
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    force dut.msg_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.msg_count_q;
    exp_count = 16'hFFFF;
    for (int i = 0; i < 2; i++) pay_mem[i] = $urandom;
    run_msg(7, 100, 100);
  endtask

  initial begin
    rst          = 1'b0;
    cmd_valid    = 1'b0;
    cmd_len      = '0;
    raw_if.valid = 1'b0;
    raw_if.data  = '0;
    raw_if.sop   = 1'b0;
    raw_if.eop   = 1'b0;
    raw_if.empty = '0;
    out_if.ready = 1'b0;
    exp_count    = '0;
    test_reset();
    test_basic();
    test_single_word();
    test_zero_len();
    test_random_stalls();
    test_back_to_back();
    test_reset_mid_msg();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
